booth_iter_mul: RTL

- Iterative radix-4 Booth multiplier for the ALU's M-extension path.
- Each cycle it slides a 3-bit window over the multiplier and decodes the zero/invert/double flags from it.
- It consumes those flags to form one partial product and accumulates it, retiring 2 multiplier bits per cycle.
- Sits between ALU operand dispatch and the ALU result mux, with valid/ready handshakes on both sides.

---
 rtl/booth_iter_mul_pkg.sv | 29 ++
 rtl/booth_pp_select.sv | 40 ++++
 rtl/booth_iter_mul.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/booth_iter_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_iter_mul_pkg
// Purpose  : Shared op codes, FSM state encodings and iteration-count helper
//            for the iterative radix-4 Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package booth_iter_mul_pkg;

  // M-extension multiply flavours carried on op_i
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Radix-4 digits needed to cover an (XLEN+2)-bit extended multiplier
  function automatic int unsigned n_iter(input int unsigned xlen);
    return (xlen + 2) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_pp_select.sv
`default_nettype none
// ============================================================================
// Module   : booth_pp_select
// Purpose  : Radix-4 Booth partial-product selector. Turns the extended
//            multiplicand and the zero/invert/double digit flags into a
//            sign-extended partial product with the negation +1 folded in.
//            Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module booth_pp_select #(
  parameter int XLEN = 64
) (
  input  logic [XLEN+1:0]   m_i,
  input  logic              zero_i,
  input  logic              invert_i,
  input  logic              double_i,
  output logic [2*XLEN+3:0] pp_o
);

  localparam int EW = XLEN + 2;
  localparam int PW = 2 * XLEN + 4;

  logic [PW-1:0] m_sx;
  logic [PW-1:0] mag;

  // Select 0, +-M or +-2M; zero wins so no stray +1 is injected for digit 0
  always_comb begin
    m_sx = {{(PW-EW){m_i[EW-1]}}, m_i};
    mag  = double_i ? (m_sx << 1) : m_sx;
    if (zero_i) begin
      pp_o = '0;
    end else if (invert_i) begin
      pp_o = ~mag + PW'(1);
    end else begin
      pp_o = mag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/booth_iter_mul.sv
`default_nettype none
// ============================================================================
// Module   : booth_iter_mul
// Purpose  : Iterative radix-4 Booth multiplier for the M-extension path.
//            Retires two multiplier bits per cycle with a fixed latency of
//            N_ITER iterations; valid/ready handshakes on both sides and a
//            flush that kills any in-flight operation.
// Revision : 1.0 - initial release
// ============================================================================
module booth_iter_mul
  import booth_iter_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int N_ITER = int'(n_iter(XLEN));
  localparam int EW     = XLEN + 2;          // extended operand width
  localparam int MW     = XLEN + 3;          // multiplier register incl. implicit 0
  localparam int PW     = 2 * XLEN + 4;      // accumulator / partial-product width
  localparam int CW     = $clog2(N_ITER + 1);
  localparam int SW     = CW + 1;            // shift amount = 2*counter

  // Registered state
  state_t          state_q;
  logic [1:0]      op_q;
  logic [EW-1:0]   mcand_q;
  logic [MW-1:0]   mplier_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q;
  logic [XLEN-1:0] result_q;
  logic            in_ready_q;
  logic            out_valid_q;

  // Combinational next-values
  logic [EW-1:0]   ext_rs1_d;
  logic [EW-1:0]   ext_rs2_d;
  logic [2:0]      window_d;
  logic            zero_d;
  logic            double_d;
  logic            invert_d;
  logic [PW-1:0]   pp_d;
  logic [SW-1:0]   shamt_d;
  logic [PW-1:0]   acc_d;
  logic            last_iter_d;
  logic [XLEN-1:0] result_d;

  // Operand extension: rs1 signed for MULH/MULHSU, rs2 signed only for MULH
  always_comb begin
    if (op_i == OP_MULH || op_i == OP_MULHSU) begin
      ext_rs1_d = {{2{rs1_i[XLEN-1]}}, rs1_i};
    end else begin
      ext_rs1_d = {2'b00, rs1_i};
    end
    if (op_i == OP_MULH) begin
      ext_rs2_d = {{2{rs2_i[XLEN-1]}}, rs2_i};
    end else begin
      ext_rs2_d = {2'b00, rs2_i};
    end
  end

  // Booth digit decode from the low 3-bit window of the multiplier register
  always_comb begin
    window_d = mplier_q[2:0];
    zero_d   = (window_d == 3'b000) || (window_d == 3'b111);
    double_d = (window_d == 3'b011) || (window_d == 3'b100);
    invert_d = window_d[2];
  end

  booth_pp_select #(
    .XLEN     (XLEN)
  ) u_pp_select (
    .m_i      (mcand_q),
    .zero_i   (zero_d),
    .invert_i (invert_d),
    .double_i (double_d),
    .pp_o     (pp_d)
  );

  // Weighted accumulation of this iteration's partial product
  always_comb begin
    shamt_d     = {cnt_q, 1'b0};
    acc_d       = acc_q + (pp_d << shamt_d);
    last_iter_d = (cnt_q == CW'(N_ITER - 1));
    if (op_q == OP_MUL) begin
      result_d = acc_d[XLEN-1:0];
    end else begin
      result_d = acc_d[2*XLEN-1:XLEN];
    end
  end

  // Controller FSM with counter, accumulator and registered handshake outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      // Flush overrides everything, including a same-cycle in_valid_i
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i && in_ready_q) begin
            op_q       <= op_i;
            mcand_q    <= ext_rs1_d;
            mplier_q   <= {ext_rs2_d, 1'b0};
            cnt_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 2;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter_d) begin
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // in_ready_q only rises once back in IDLE, never on the handshake cycle
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule
`default_nettype wire
